fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined LEGv8 core, directly upstream of decode.
- Holds the PC and issues requests to a variable-latency instruction memory.
- Captures returned words into the IF/ID pipeline register. The decode sign-extender and register file consume that register.
- Handles decode stalls with a one-entry skid buffer, and handles execute-stage branch redirects, including one that arrives while a memory request is in flight.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/if_id_reg.sv | 32 +++
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
// Imported by fetch_stage and if_id_reg.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DROP
    } fetch_state_t;

    localparam logic [63:0] PC_INC       = 64'd4;
    localparam logic [31:0] INSTR_BUBBLE = 32'h0;

    function automatic logic [63:0] align(input logic [63:0] a);
        return a & ~64'h3;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise hold.
// Reset and flush both leave an all-zero bubble.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [63:0] pc_in,
    output logic [31:0] instr,
    output logic [63:0] pc,
    output logic        valid
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr <= INSTR_BUBBLE;
            pc    <= 64'h0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= INSTR_BUBBLE;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc    <= pc_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, variable-latency imem requests, skid buffer,
// and redirect handling including redirects during an in-flight request.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_D,
    input  logic               branch_taken_E,
    input  logic [63:0]        branch_target_E,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_valid,
    input  logic [31:0]        imem_rdata,
    output logic [63:0]        pc_F,
    output logic [31:0]        instr_D,
    output logic [63:0]        pc_D,
    output logic               valid_D
);

    fetch_state_t       state, state_n;
    logic [63:0]        pc_n, pc_inc, tgt;
    logic [IMEM_AW-1:0] req_addr, req_n;
    logic [31:0]        skid_instr;
    logic [63:0]        skid_pc;
    logic               skid_load, done;
    logic               ifid_load, ifid_flush;
    logic [31:0]        ifid_instr;
    logic [63:0]        ifid_pc;

    assign done      = imem_req && imem_valid;
    assign tgt       = align(branch_target_E);
    assign pc_inc    = pc_F + PC_INC;
    assign imem_addr = req_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            FETCH: begin
                if (branch_taken_E)  state_n = done ? FETCH : DROP;
                else if (done && stall_D) state_n = HOLD;
            end
            HOLD: begin
                if (branch_taken_E || !stall_D) state_n = FETCH;
            end
            DROP: begin
                if (done) state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    always_comb begin
        imem_req   = reset && (state != HOLD);
        pc_n       = pc_F;
        req_n      = req_addr;
        skid_load  = 1'b0;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_instr = imem_rdata;
        ifid_pc    = pc_F;
        if (branch_taken_E) begin
            pc_n       = tgt;
            ifid_flush = 1'b1;
            // an unfinished request must complete at its old address first
            if (state == HOLD || done) req_n = tgt[IMEM_AW+1:2];
        end else begin
            unique case (state)
                FETCH: begin
                    if (done && !stall_D) begin
                        ifid_load = 1'b1;
                        pc_n      = pc_inc;
                        req_n     = pc_inc[IMEM_AW+1:2];
                    end else if (done) begin
                        skid_load = 1'b1;
                    end else if (!stall_D) begin
                        ifid_flush = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall_D) begin
                        ifid_load  = 1'b1;
                        ifid_instr = skid_instr;
                        ifid_pc    = skid_pc;
                        pc_n       = pc_inc;
                        req_n      = pc_inc[IMEM_AW+1:2];
                    end
                end
                DROP: begin
                    if (done)     req_n = pc_F[IMEM_AW+1:2];
                    if (!stall_D) ifid_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_F       <= RESET_PC;
            req_addr   <= RESET_PC[IMEM_AW+1:2];
            skid_instr <= INSTR_BUBBLE;
            skid_pc    <= 64'h0;
        end else begin
            pc_F     <= pc_n;
            req_addr <= req_n;
            if (skid_load) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc_F;
            end
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .reset    (reset),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .instr_in (ifid_instr),
        .pc_in    (ifid_pc),
        .instr    (instr_D),
        .pc       (pc_D),
        .valid    (valid_D)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for single-cycle behaviour
// plus hand sequences for in-flight redirect and asynchronous reset.
module tb_fetch_stage;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall_D;
    logic          branch_taken_E;
    logic [63:0]   branch_target_E;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_valid;
    logic [31:0]   imem_rdata;
    logic [63:0]   pc_F;
    logic [31:0]   instr_D;
    logic [63:0]   pc_D;
    logic          valid_D;

    int errors = 0;
    int checks = 0;
    int lat    = 0;
    int wcnt   = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(64'h0), .IMEM_AW(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_D         (stall_D),
        .branch_taken_E  (branch_taken_E),
        .branch_target_E (branch_target_E),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_valid      (imem_valid),
        .imem_rdata      (imem_rdata),
        .pc_F            (pc_F),
        .instr_D         (instr_D),
        .pc_D            (pc_D),
        .valid_D         (valid_D)
    );

    // memory: responds after lat extra cycles of a held request
    assign imem_valid = imem_req && (wcnt >= lat);
    assign imem_rdata = 32'hF800_0000 + {24'h0, imem_addr};

    always @(posedge clk) begin
        if (imem_req && !imem_valid) wcnt <= wcnt + 1;
        else                         wcnt <= 0;
    end

    typedef struct {
        logic          stall;
        logic          br;
        logic [63:0]   tgt;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_valid;
        logic [63:0]   e_pcd;
        logic [31:0]   e_instr;
        logic [63:0]   e_pcf;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic b, input logic [63:0] t);
        stall_D         = s;
        branch_taken_E  = b;
        branch_target_E = t;
        #1;
    endtask

    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        vt[0]  = '{0, 0, 0,      1, 8'h00, 1, 64'h0,   32'hF8000000, 64'h4};
        vt[1]  = '{0, 0, 0,      1, 8'h01, 1, 64'h4,   32'hF8000001, 64'h8};
        vt[2]  = '{1, 0, 0,      1, 8'h02, 1, 64'h4,   32'hF8000001, 64'h8};
        vt[3]  = '{1, 0, 0,      0, 8'h02, 1, 64'h4,   32'hF8000001, 64'h8};
        vt[4]  = '{1, 0, 0,      0, 8'h02, 1, 64'h4,   32'hF8000001, 64'h8};
        vt[5]  = '{0, 0, 0,      0, 8'h02, 1, 64'h8,   32'hF8000002, 64'hC};
        vt[6]  = '{0, 0, 0,      1, 8'h03, 1, 64'hC,   32'hF8000003, 64'h10};
        vt[7]  = '{1, 0, 0,      1, 8'h04, 1, 64'hC,   32'hF8000003, 64'h10};
        vt[8]  = '{1, 1, 64'h41, 0, 8'h04, 0, 64'h0,   32'h0,        64'h40};
        vt[9]  = '{0, 0, 0,      1, 8'h10, 1, 64'h40,  32'hF8000010, 64'h44};
        vt[10] = '{1, 1, 64'h200,1, 8'h11, 0, 64'h0,   32'h0,        64'h200};
        vt[11] = '{0, 0, 0,      1, 8'h80, 1, 64'h200, 32'hF8000080, 64'h204};
        vt[12] = '{0, 1, '1,     1, 8'h81, 0, 64'h0,   32'h0,        TOP};
        vt[13] = '{0, 0, 0,      1, 8'hFF, 1, TOP,     32'hF80000FF, 64'h0};
        vt[14] = '{0, 0, 0,      1, 8'h00, 1, 64'h0,   32'hF8000000, 64'h4};

        reset = 1'b0;
        drive(0, 0, 0);
        repeat (3) begin
            tick();
            chk("rst_req", imem_req, 0);
            chk("rst_addr", imem_addr, 0);
            chk("rst_valid", valid_D, 0);
            chk("rst_pcf", pc_F, 0);
            chk("rst_instr", instr_D, 0);
        end
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].stall, vt[i].br, vt[i].tgt);
            chk($sformatf("v%0d_req", i), imem_req, vt[i].e_req);
            chk($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
            tick();
            chk($sformatf("v%0d_valid", i), valid_D, vt[i].e_valid);
            chk($sformatf("v%0d_instr", i), instr_D, vt[i].e_instr);
            chk($sformatf("v%0d_pcf", i), pc_F, vt[i].e_pcf);
            if (vt[i].e_valid)
                chk($sformatf("v%0d_pcd", i), pc_D, vt[i].e_pcd);
        end

        // three-cycle latency: bubbles while waiting on word 1
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0);
            chk("lat_addr", imem_addr, 8'h01);
            tick();
            chk("lat_bubble", valid_D, 0);
        end
        drive(0, 0, 0);
        tick();
        chk("lat_valid", valid_D, 1);
        chk("lat_pcd", pc_D, 64'h4);
        chk("lat_instr", instr_D, 32'hF8000001);

        // redirect one cycle into the word-2 request
        drive(0, 0, 0);
        chk("fl_addr0", imem_addr, 8'h02);
        tick();
        drive(0, 1, 64'h100);
        chk("fl_addr1", imem_addr, 8'h02);
        tick();
        chk("fl_pcf", pc_F, 64'h100);
        chk("fl_valid1", valid_D, 0);
        drive(0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            chk("fl_req_hold", imem_req, 1);
            chk("fl_addr_hold", imem_addr, 8'h02);
            tick();
            chk("fl_no_word2", valid_D, 0);
        end
        chk("fl_next_addr", imem_addr, 8'h40);
        begin
            int n = 0;
            while (!valid_D && n < 10) begin
                tick();
                n++;
            end
        end
        chk("fl_wait_valid", valid_D, 1);
        chk("fl_pcd", pc_D, 64'h100);
        chk("fl_instr", instr_D, 32'hF8000040);

        // second redirect in DROP, then asynchronous reset mid-request
        drive(0, 1, 64'h300);
        tick();
        drive(0, 1, 64'h400);
        chk("dr_addr1", imem_addr, 8'h41);
        tick();
        chk("dr_pcf", pc_F, 64'h400);
        drive(0, 0, 0);
        chk("dr_req", imem_req, 1);
        chk("dr_addr2", imem_addr, 8'h41);
        reset = 1'b0;
        #1;
        chk("ar_req", imem_req, 0);
        chk("ar_pcf", pc_F, 0);
        chk("ar_valid", valid_D, 0);
        chk("ar_instr", instr_D, 0);
        chk("ar_pcd", pc_D, 0);
        chk("ar_addr", imem_addr, 0);
        lat = 0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("ar_req_rel", imem_req, 1);
        chk("ar_addr_rel", imem_addr, 0);
        tick();
        chk("ar_valid_rel", valid_D, 1);
        chk("ar_pcd_rel", pc_D, 0);
        chk("ar_instr_rel", instr_D, 32'hF8000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
